// File: rtl/fifo_gen_status_pkg.sv
// fifo_gen_status_pkg: field layout of the 10GE status vector and FIFO defaults.
package fifo_gen_status_pkg;
   localparam int STATUS_WIDTH = 458;
   localparam int STATUS_DEPTH = 16;
   localparam int PCSPMA_LSB   = 0;
   localparam int PCSPMA_MSB   = 7;
   localparam int MAC_LSB      = 8;
   localparam int MAC_MSB      = 9;
   localparam int PCS_PMA_LSB  = 10;
   localparam int PCS_PMA_MSB  = 457;
   typedef struct packed {
      logic [PCS_PMA_MSB-PCS_PMA_LSB:0] pcs_pma;
      logic [MAC_MSB-MAC_LSB:0]         mac;
      logic [PCSPMA_MSB-PCSPMA_LSB:0]   pcspma;
   } status_t;
endpackage

// File: rtl/fifo_gen_status_if.sv
// fifo_gen_status_if: write/read handshake and status flags of the status FIFO.
interface fifo_gen_status_if #(
   parameter int C_DATA_WIDTH = 458,
   parameter int C_CNT_WIDTH  = 5
);
   logic [C_DATA_WIDTH-1:0] din;
   logic                    wr_en;
   logic                    rd_en;
   logic [C_DATA_WIDTH-1:0] dout;
   logic                    valid;
   logic                    full;
   logic                    empty;
   logic [C_CNT_WIDTH-1:0]  data_count;
   modport master (output din, wr_en, rd_en, input dout, valid, full, empty, data_count);
   modport slave  (input din, wr_en, rd_en, output dout, valid, full, empty, data_count);
endinterface

// File: rtl/fifo_gen_status_ram.sv
// fifo_gen_status_ram: register array with one write port and a registered read port.
module fifo_gen_status_ram #(
   parameter int C_DATA_WIDTH = 458,
   parameter int C_DEPTH      = 16,
   localparam int AW          = $clog2(C_DEPTH)
) (
   input  logic                    clk156,
   input  logic                    areset_clk156,
   input  logic                    we,
   input  logic [AW-1:0]           waddr,
   input  logic [C_DATA_WIDTH-1:0] wdata,
   input  logic                    re,
   input  logic [AW-1:0]           raddr,
   output logic [C_DATA_WIDTH-1:0] rdata
);
   logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
   // Storage is never reset; only the output register is.
   always_ff @(posedge clk156)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk156 or posedge areset_clk156)
      if (areset_clk156) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_gen_status.sv
// fifo_gen_status: single-clock FIFO carrying the 10GE status vector,
// with registered read data and flags derived from the next-state count.
module fifo_gen_status
   import fifo_gen_status_pkg::*;
#(
   parameter int C_DATA_WIDTH = STATUS_WIDTH,
   parameter int C_DEPTH      = STATUS_DEPTH,
   parameter int C_CNT_WIDTH  = $clog2(C_DEPTH) + 1
) (
   input logic              clk156,
   input logic              areset_clk156,
   fifo_gen_status_if.slave fifo
);
   localparam int AW = $clog2(C_DEPTH);
   logic [AW-1:0]           wptr, rptr;
   logic [C_CNT_WIDTH-1:0]  cnt, cnt_nxt;
   logic                    full, empty, valid, wr_ok, rd_ok;
   logic [C_DATA_WIDTH-1:0] dout;
   // Both requests are judged against the flags registered at the start of the cycle.
   assign wr_ok   = fifo.wr_en & ~full;
   assign rd_ok   = fifo.rd_en & ~empty;
   assign cnt_nxt = cnt + C_CNT_WIDTH'(wr_ok) - C_CNT_WIDTH'(rd_ok);
   always_ff @(posedge clk156 or posedge areset_clk156)
      if (areset_clk156) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         valid <= 1'b0;
      end else begin
         wptr  <= wptr + AW'(wr_ok);
         rptr  <= rptr + AW'(rd_ok);
         cnt   <= cnt_nxt;
         full  <= cnt_nxt == C_CNT_WIDTH'(C_DEPTH);
         empty <= cnt_nxt == '0;
         valid <= rd_ok;
      end
   fifo_gen_status_ram #(
      .C_DATA_WIDTH(C_DATA_WIDTH),
      .C_DEPTH     (C_DEPTH)
   ) u_ram (
      .clk156       (clk156),
      .areset_clk156(areset_clk156),
      .we           (wr_ok),
      .waddr        (wptr),
      .wdata        (fifo.din),
      .re           (rd_ok),
      .raddr        (rptr),
      .rdata        (dout)
   );
   assign fifo.dout       = dout;
   assign fifo.valid      = valid;
   assign fifo.full       = full;
   assign fifo.empty      = empty;
   assign fifo.data_count = cnt;
endmodule

// File: tb/tb_fifo_gen_status.sv
// tb_fifo_gen_status: directed checks of the status FIFO against hand-computed values.
module tb_fifo_gen_status;
   localparam int DW    = 458;
   localparam int DEPTH = 16;
   localparam int CW    = 5;
   logic clk156        = 1'b0;
   logic areset_clk156 = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [DW-1:0] a5_word;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_w;
   fifo_gen_status_if #(.C_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) f ();
   fifo_gen_status #(
      .C_DATA_WIDTH(DW),
      .C_DEPTH     (DEPTH),
      .C_CNT_WIDTH (CW)
   ) dut (
      .clk156       (clk156),
      .areset_clk156(areset_clk156),
      .fifo         (f)
   );
   always #5 clk156 = ~clk156;
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk156);
      #1;
   endtask
   task automatic chk_state(input string tag, input int cnt, input bit e, input bit fl);
      chk({tag, ".count"}, DW'(f.data_count), DW'(cnt));
      chk({tag, ".empty"}, DW'(f.empty), DW'(e));
      chk({tag, ".full"}, DW'(f.full), DW'(fl));
   endtask
   initial begin
      bit wok, rok;
      int nxt;
      f.din   = '0;
      f.wr_en = 1'b0;
      f.rd_en = 1'b0;
      a5_word = '0;
      a5_word[9:0] = 10'b10_1010_0101;
      #12;
      chk_state("por", 0, 1'b1, 1'b0);
      chk("por.valid", DW'(f.valid), DW'(0));
      chk("por.dout", f.dout, '0);
      areset_clk156 = 1'b0;
      tick();
      // single word: write, read on the next edge
      f.din   = a5_word;
      f.wr_en = 1'b1;
      tick();
      f.wr_en = 1'b0;
      chk_state("single.wr", 1, 1'b0, 1'b0);
      f.rd_en = 1'b1;
      tick();
      f.rd_en = 1'b0;
      chk("single.valid", DW'(f.valid), DW'(1));
      chk("single.pcspma", DW'(f.dout[7:0]), DW'(8'hA5));
      chk("single.mac", DW'(f.dout[9:8]), DW'(2));
      chk_state("single.rd", 0, 1'b1, 1'b0);
      tick();
      chk("single.valid_drop", DW'(f.valid), DW'(0));
      chk("single.hold", f.dout, a5_word);
      // read while empty
      f.rd_en = 1'b1;
      tick();
      f.rd_en = 1'b0;
      chk("empty_rd.valid", DW'(f.valid), DW'(0));
      chk("empty_rd.dout", f.dout, a5_word);
      chk_state("empty_rd", 0, 1'b1, 1'b0);
      // fill to full, overflow write dropped, drain in order
      f.wr_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         f.din = DW'(i);
         tick();
      end
      chk_state("fill", 16, 1'b0, 1'b1);
      f.din = DW'(77);
      tick();
      f.wr_en = 1'b0;
      chk_state("overflow", 16, 1'b0, 1'b1);
      f.rd_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk($sformatf("drain%0d.dout", i), f.dout, DW'(i));
         chk($sformatf("drain%0d.valid", i), DW'(f.valid), DW'(1));
      end
      f.rd_en = 1'b0;
      chk_state("drained", 0, 1'b1, 1'b0);
      tick();
      chk("drained.valid", DW'(f.valid), DW'(0));
      // simultaneous write and read while full
      f.wr_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         f.din = DW'(100 + i);
         tick();
      end
      f.din   = DW'(99);
      f.rd_en = 1'b1;
      tick();
      f.wr_en = 1'b0;
      chk("simul.dout", f.dout, DW'(100));
      chk("simul.valid", DW'(f.valid), DW'(1));
      chk_state("simul", 15, 1'b0, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         tick();
         chk($sformatf("simul_drain%0d", i), f.dout, DW'(100 + i));
      end
      f.rd_en = 1'b0;
      chk_state("simul_drained", 0, 1'b1, 1'b0);
      // asynchronous reset with 5 entries stored and valid output
      f.wr_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         f.din = DW'(200 + i);
         tick();
      end
      f.wr_en = 1'b0;
      f.rd_en = 1'b1;
      tick();
      f.rd_en = 1'b0;
      chk("pre_rst.dout", f.dout, DW'(200));
      chk_state("pre_rst", 5, 1'b0, 1'b0);
      #2 areset_clk156 = 1'b1;
      #1;
      chk_state("rst", 0, 1'b1, 1'b0);
      chk("rst.valid", DW'(f.valid), DW'(0));
      chk("rst.dout", f.dout, '0);
      #3 areset_clk156 = 1'b0;
      f.din   = DW'(300);
      f.wr_en = 1'b1;
      tick();
      f.wr_en = 1'b0;
      chk_state("post_rst.wr", 1, 1'b0, 1'b0);
      f.rd_en = 1'b1;
      tick();
      f.rd_en = 1'b0;
      chk("post_rst.dout", f.dout, DW'(300));
      chk("post_rst.valid", DW'(f.valid), DW'(1));
      // steady stream across pointer wrap, reads stalled every fifth cycle
      nxt = 1000;
      for (int k = 0; k < 40; k++) begin
         f.wr_en = 1'b1;
         f.rd_en = (k % 5) != 4;
         f.din   = DW'(nxt);
         wok = exp_q.size() < DEPTH;
         rok = f.rd_en && exp_q.size() > 0;
         exp_w = '0;
         if (rok) exp_w = exp_q.pop_front();
         if (wok) begin
            exp_q.push_back(DW'(nxt));
            nxt++;
         end
         tick();
         chk($sformatf("stream%0d.valid", k), DW'(f.valid), DW'(rok));
         if (rok) chk($sformatf("stream%0d.dout", k), f.dout, exp_w);
         chk($sformatf("stream%0d.count", k), DW'(f.data_count), DW'(exp_q.size()));
      end
      f.wr_en = 1'b0;
      f.rd_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
